// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature A/B step decoder with glitch filter and wrapping position
module quad_step_decoder #(
  parameter int N    = 8,
  parameter int FILT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         sync_clear,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic         inc_tick,
  output logic         dec_tick,
  output logic         err_tick,
  output logic         dir,
  output logic [N-1:0] pos,
  output logic         min_tick,
  output logic         max_tick
);

  // Filter terminal count: a pin flips on the FILT-th consecutive mismatching edge.
  localparam logic [3:0] LAST = 4'(FILT - 1);

  logic       a_s1, a_s2, b_s1, b_s2;
  logic       a_f, b_f;
  logic       a_p, b_p;
  logic [3:0] a_cnt, b_cnt;
  logic       fwd, rev, bad;
  logic [1:0] prev_ab, cur_ab;

  // Two-flop synchronisers; left unreset so the pins settle before reset release.
  always_ff @(posedge clk) begin
    a_s1 <= a_in;
    a_s2 <= a_s1;
    b_s1 <= b_in;
    b_s2 <= b_s1;
  end

  // Glitch filters: count consecutive edges where the synced pin disagrees with f.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_f   <= a_s2;
      b_f   <= b_s2;
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_s2 == a_f) begin
        a_cnt <= '0;
      end else if (a_cnt == LAST) begin
        a_f   <= a_s2;
        a_cnt <= '0;
      end else begin
        a_cnt <= a_cnt + 4'd1;
      end
      if (b_s2 == b_f) begin
        b_cnt <= '0;
      end else if (b_cnt == LAST) begin
        b_f   <= b_s2;
        b_cnt <= '0;
      end else begin
        b_cnt <= b_cnt + 4'd1;
      end
    end
  end

  // Gray-code transition classification between the previous and current filtered pair.
  always_comb begin
    prev_ab = {a_p, b_p};
    cur_ab  = {a_f, b_f};
    fwd     = 1'b0;
    rev     = 1'b0;
    bad     = ((prev_ab ^ cur_ab) == 2'b11);
    case (prev_ab)
      2'b00: begin fwd = (cur_ab == 2'b01); rev = (cur_ab == 2'b10); end
      2'b01: begin fwd = (cur_ab == 2'b11); rev = (cur_ab == 2'b00); end
      2'b11: begin fwd = (cur_ab == 2'b10); rev = (cur_ab == 2'b01); end
      default: begin fwd = (cur_ab == 2'b00); rev = (cur_ab == 2'b11); end
    endcase
  end

  // Registered ticks, direction and position; clear beats load beats stepping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_p      <= a_s2;
      b_p      <= b_s2;
      inc_tick <= 1'b0;
      dec_tick <= 1'b0;
      err_tick <= 1'b0;
      dir      <= 1'b0;
      pos      <= '0;
    end else begin
      a_p      <= a_f;
      b_p      <= b_f;
      inc_tick <= fwd;
      dec_tick <= rev;
      err_tick <= bad;
      if (fwd) begin
        dir <= 1'b1;
      end else if (rev) begin
        dir <= 1'b0;
      end
      if (sync_clear) begin
        pos <= '0;
      end else if (load) begin
        pos <= d;
      end else if (fwd) begin
        pos <= pos + 1'b1;
      end else if (rev) begin
        pos <= pos - 1'b1;
      end
    end
  end

  assign min_tick = (pos == '0);
  assign max_tick = (pos == '1);

endmodule
